// File: rtl/vpu_sram_rd_port_ctrl.sv
// Read-port responder: takes one VPU source burst and steers its beats onto the latched SRAM bank.
// Latency: sram_csb_o/sram_addr_o follow reb_i combinationally; rvalid_o rises RD_LAT+1 cycles after each beat.
// Backpressure: none once the burst is granted; a busy bank only stalls the grant while in IDLE.
module vpu_sram_rd_port_ctrl #(
    parameter int BANK_CNT       = 4,
    parameter int BANK_CNT_LG2   = 2,
    parameter int BANK_DEPTH_LG2 = 10,
    parameter int DATA_WIDTH     = 256,
    parameter int RD_LAT         = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rreq_i,
    input  logic [BANK_CNT_LG2-1:0]        rid_i,
    input  logic [BANK_DEPTH_LG2-1:0]      raddr_i,
    input  logic                           reb_i,
    input  logic                           rlast_i,
    output logic                           rack_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           rvalid_o,
    input  logic [BANK_CNT-1:0]            bank_busy_i,
    output logic [BANK_CNT-1:0]            bank_lock_o,
    output logic [BANK_CNT-1:0]            sram_csb_o,
    output logic [BANK_DEPTH_LG2-1:0]      sram_addr_o,
    input  logic [BANK_CNT*DATA_WIDTH-1:0] sram_rdata_i,
    output logic                           err_o
);

    typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [BANK_CNT_LG2-1:0]     bank_q;
    logic [BANK_DEPTH_LG2-1:0]   addr_q;
    logic [RD_LAT-1:0]           pipe_q;
    logic [BANK_CNT-1:0]         bank_oh;
    logic                        issue;
    logic                        set_err;

    // State register, latched bank and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == GRANT)
                bank_q <= rid_i;
            if (set_err)
                err_o <= 1'b1;
        end
    end

    // Next-state logic; an early drop of rreq_i inside a burst is flagged as an error
    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        case (state_q)
            IDLE:  if (rreq_i && !bank_busy_i[rid_i]) state_d = GRANT;
            GRANT: state_d = BURST;
            BURST: begin
                if (issue && rlast_i) begin
                    state_d = DRAIN;
                end else if (!rreq_i) begin
                    state_d = DRAIN;
                    set_err = 1'b1;
                end
            end
            DRAIN: if (pipe_q == '0 && !rreq_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; beats drive the SRAM straight from the request inputs
    always_comb begin
        bank_oh     = BANK_CNT'(1) << bank_q;
        rack_o      = (state_q == GRANT);
        bank_lock_o = (state_q != IDLE) ? bank_oh : '0;
        issue       = (state_q == BURST) && !reb_i;
        sram_csb_o  = issue ? ~bank_oh : '1;
        sram_addr_o = issue ? raddr_i : addr_q;
    end

    // Hold the last issued address so idle cycles leave the SRAM address bus stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_q <= '0;
        else if (issue)
            addr_q <= raddr_i;
    end

    // Valid shift register tracking beats through the SRAM macro latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pipe_q <= '0;
        else
            pipe_q <= (pipe_q << 1) | RD_LAT'(issue);
    end

    // Capture bank data as each tracked beat matures; rdata_o holds between beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= pipe_q[RD_LAT-1];
            if (pipe_q[RD_LAT-1])
                rdata_o <= sram_rdata_i[bank_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_vpu_sram_rd_port_ctrl.sv
// Directed bench: two instances (RD_LAT=1 and RD_LAT=3) share stimulus and a behavioural SRAM model.
// Latency: bank model returns data RD_LAT cycles after the csb-low cycle.
// Backpressure: none; all stimulus is fixed-cycle.
module tb_vpu_sram_rd_port_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rreq, reb, rlast;
    logic [1:0]    rid;
    logic [9:0]    raddr;
    logic [3:0]    busy;

    logic          rack1, rvalid1, err1, rack3, rvalid3, err3;
    logic [DW-1:0] rdata1, rdata3;
    logic [3:0]    lock1, csb1, lock3, csb3;
    logic [9:0]    saddr1, saddr3;
    logic [4*DW-1:0] srd1, srd3;

    int vec = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vpu_sram_rd_port_ctrl #(.BANK_CNT(4), .BANK_CNT_LG2(2), .BANK_DEPTH_LG2(10),
                            .DATA_WIDTH(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rreq_i(rreq), .rid_i(rid), .raddr_i(raddr),
        .reb_i(reb), .rlast_i(rlast), .rack_o(rack1), .rdata_o(rdata1), .rvalid_o(rvalid1),
        .bank_busy_i(busy), .bank_lock_o(lock1), .sram_csb_o(csb1), .sram_addr_o(saddr1),
        .sram_rdata_i(srd1), .err_o(err1));

    vpu_sram_rd_port_ctrl #(.BANK_CNT(4), .BANK_CNT_LG2(2), .BANK_DEPTH_LG2(10),
                            .DATA_WIDTH(DW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rreq_i(rreq), .rid_i(rid), .raddr_i(raddr),
        .reb_i(reb), .rlast_i(rlast), .rack_o(rack3), .rdata_o(rdata3), .rvalid_o(rvalid3),
        .bank_busy_i(busy), .bank_lock_o(lock3), .sram_csb_o(csb3), .sram_addr_o(saddr3),
        .sram_rdata_i(srd3), .err_o(err3));

    function automatic logic [DW-1:0] mdat(input int b, input int a);
        return 32'hB000_0000 | 32'(b << 16) | 32'(a);
    endfunction

    // SRAM bank model: address captured on csb-low edge, data appears RD_LAT cycles after the read cycle
    logic [9:0] m1 [4];
    logic [9:0] m3 [4][3];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!csb1[b]) m1[b] <= saddr1;
            if (!csb3[b]) m3[b][0] <= saddr3;
            m3[b][1] <= m3[b][0];
            m3[b][2] <= m3[b][1];
        end
    end
    always_comb begin
        srd1 = '0;
        srd3 = '0;
        for (int b = 0; b < 4; b++) begin
            srd1[b*DW +: DW] = mdat(b, int'(m1[b]));
            srd3[b*DW +: DW] = mdat(b, int'(m3[b][2]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        rreq = 1'b0; reb = 1'b1; rlast = 1'b0; busy = 4'h0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rreq = 1'b0; reb = 1'b1; rlast = 1'b0; rid = 2'd0; raddr = 10'd0; busy = 4'h0;
        repeat (3) tick();
        vec++; if (rack1 !== 1'b0) begin fails++; $display("FAIL rst_rack got %h want 0", rack1); end
        vec++; if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0) begin fails++; $display("FAIL rst_rvalid got %h/%h want 0", rvalid1, rvalid3); end
        vec++; if (rdata1 !== '0) begin fails++; $display("FAIL rst_rdata got %h want 0", rdata1); end
        vec++; if (lock1 !== 4'h0) begin fails++; $display("FAIL rst_lock got %h want 0", lock1); end
        vec++; if (csb1 !== 4'hF) begin fails++; $display("FAIL rst_csb got %h want f", csb1); end
        vec++; if (saddr1 !== 10'd0) begin fails++; $display("FAIL rst_addr got %h want 0", saddr1); end
        vec++; if (err1 !== 1'b0) begin fails++; $display("FAIL rst_err got %h want 0", err1); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_burst();
        rid = 2'd2; rreq = 1'b1;
        tick();
        vec++; if (rack1 !== 1'b1) begin fails++; $display("FAIL basic_rack got %h want 1", rack1); end
        vec++; if (lock1 !== 4'b0100) begin fails++; $display("FAIL basic_lock_grant got %h want 4", lock1); end
        tick();
        vec++; if (rack1 !== 1'b0) begin fails++; $display("FAIL basic_rack_pulse got %h want 0", rack1); end
        for (int i = 0; i < 7; i++) begin
            if (i >= 2 && i <= 5) begin
                vec++; if (rvalid1 !== 1'b1 || rdata1 !== mdat(2, 16 + i - 2)) begin
                    fails++; $display("FAIL basic_rdata%0d got v=%h d=%h want v=1 d=%h", i, rvalid1, rdata1, mdat(2, 16 + i - 2)); end
            end else begin
                vec++; if (rvalid1 !== 1'b0) begin fails++; $display("FAIL basic_novalid%0d got %h want 0", i, rvalid1); end
            end
            if (i < 4) begin
                reb = 1'b0; raddr = 10'(16 + i); rlast = (i == 3);
                #1;
                vec++; if (csb1 !== 4'b1011 || saddr1 !== 10'(16 + i)) begin
                    fails++; $display("FAIL basic_beat%0d got csb=%h a=%h want csb=b a=%h", i, csb1, saddr1, 16 + i); end
            end else begin
                reb = 1'b1; rlast = 1'b0;
                #1;
                vec++; if (csb1 !== 4'hF || saddr1 !== 10'h13) begin
                    fails++; $display("FAIL basic_idle%0d got csb=%h a=%h want csb=f a=13", i, csb1, saddr1); end
            end
            vec++; if (lock1 !== 4'b0100) begin fails++; $display("FAIL basic_lock%0d got %h want 4", i, lock1); end
            tick();
        end
        // rreq held after rlast: DRAIN keeps the lock and never re-grants
        for (int i = 0; i < 3; i++) begin
            vec++; if (rack1 !== 1'b0 || lock1 !== 4'b0100) begin
                fails++; $display("FAIL drain_hold%0d got rack=%h lock=%h want rack=0 lock=4", i, rack1, lock1); end
            tick();
        end
        rreq = 1'b0;
        tick();
        vec++; if (lock1 !== 4'h0) begin fails++; $display("FAIL drain_exit got lock=%h want 0", lock1); end
        vec++; if (err1 !== 1'b0) begin fails++; $display("FAIL basic_err got %h want 0", err1); end
        settle();
    endtask

    task automatic test_busy_stall();
        rid = 2'd1; busy = 4'b0010; rreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++; if (rack1 !== 1'b0) begin fails++; $display("FAIL busy_rack%0d got %h want 0", i, rack1); end
        end
        busy = 4'h0;
        tick();
        vec++; if (rack1 !== 1'b1 || lock1 !== 4'b0010) begin
            fails++; $display("FAIL busy_grant got rack=%h lock=%h want rack=1 lock=2", rack1, lock1); end
        tick();
        vec++; if (rack1 !== 1'b0) begin fails++; $display("FAIL busy_rack_pulse got %h want 0", rack1); end
        reb = 1'b0; raddr = 10'h20; rlast = 1'b1;
        #1;
        vec++; if (csb1 !== 4'b1101) begin fails++; $display("FAIL busy_csb got %h want d", csb1); end
        tick();
        rreq = 1'b0; reb = 1'b1; rlast = 1'b0;
        tick();
        vec++; if (rvalid1 !== 1'b1 || rdata1 !== mdat(1, 32)) begin
            fails++; $display("FAIL busy_rdata got v=%h d=%h want v=1 d=%h", rvalid1, rdata1, mdat(1, 32)); end
        settle();
    endtask

    task automatic test_gaps_lat3();
        int n = 0;
        int r = 0;
        logic expv;
        rid = 2'd0; rreq = 1'b1;
        tick();
        vec++; if (rack3 !== 1'b1) begin fails++; $display("FAIL gap_rack got %h want 1", rack3); end
        tick();
        for (int k = 0; k < 10; k++) begin
            expv = (k == 4 || k == 6 || k == 7);
            vec++; if (rvalid3 !== expv) begin fails++; $display("FAIL gap_valid%0d got %h want %h", k, rvalid3, expv); end
            if (expv) begin
                vec++; if (rdata3 !== mdat(0, 48 + r)) begin
                    fails++; $display("FAIL gap_rdata%0d got %h want %h", k, rdata3, mdat(0, 48 + r)); end
                r++;
            end
            if (k == 0 || k == 2 || k == 3) begin
                reb = 1'b0; raddr = 10'(48 + n); rlast = (k == 3); n++;
            end else begin
                reb = 1'b1; rlast = 1'b0;
            end
            if (k >= 4) rreq = 1'b0;
            tick();
        end
        vec++; if (err3 !== 1'b0) begin fails++; $display("FAIL gap_err got %h want 0", err3); end
        settle();
    endtask

    task automatic test_abort();
        vec++; if (err1 !== 1'b0) begin fails++; $display("FAIL abort_err_pre got %h want 0", err1); end
        rid = 2'd3; rreq = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k == 2 || k == 3) begin
                vec++; if (rvalid1 !== 1'b1 || rdata1 !== mdat(3, 64 + k - 2)) begin
                    fails++; $display("FAIL abort_rdata%0d got v=%h d=%h want v=1 d=%h", k, rvalid1, rdata1, mdat(3, 64 + k - 2)); end
            end else begin
                vec++; if (rvalid1 !== 1'b0) begin fails++; $display("FAIL abort_novalid%0d got %h want 0", k, rvalid1); end
            end
            vec++; if (err1 !== (k >= 3)) begin fails++; $display("FAIL abort_err%0d got %h want %h", k, err1, k >= 3); end
            if (k < 2) begin
                reb = 1'b0; raddr = 10'(64 + k); rlast = 1'b0;
            end else begin
                reb = 1'b1; rreq = 1'b0;
            end
            tick();
        end
        rid = 2'd0; rreq = 1'b1;
        tick();
        vec++; if (rack1 !== 1'b1 || err1 !== 1'b1) begin
            fails++; $display("FAIL abort_regrant got rack=%h err=%h want rack=1 err=1", rack1, err1); end
        tick();
        reb = 1'b0; raddr = 10'h44; rlast = 1'b1;
        tick();
        rreq = 1'b0; reb = 1'b1; rlast = 1'b0;
        tick();
        vec++; if (rvalid1 !== 1'b1 || rdata1 !== mdat(0, 68)) begin
            fails++; $display("FAIL abort_next_rdata got v=%h d=%h want v=1 d=%h", rvalid1, rdata1, mdat(0, 68)); end
        settle();
        vec++; if (err1 !== 1'b1) begin fails++; $display("FAIL abort_sticky got %h want 1", err1); end
    endtask

    task automatic test_reset_mid_burst();
        rid = 2'd2; rreq = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            reb = 1'b0; raddr = 10'(80 + k); rlast = 1'b0;
            if (k < 2) tick();
        end
        #1;
        vec++; if (rvalid1 !== 1'b1 || csb1 !== 4'b1011) begin
            fails++; $display("FAIL mid_pre got v=%h csb=%h want v=1 csb=b", rvalid1, csb1); end
        rst_n = 1'b0;
        #1;
        vec++; if (csb1 !== 4'hF || csb3 !== 4'hF) begin fails++; $display("FAIL mid_csb got %h/%h want f", csb1, csb3); end
        vec++; if (rvalid1 !== 1'b0) begin fails++; $display("FAIL mid_rvalid got %h want 0", rvalid1); end
        vec++; if (lock1 !== 4'h0 || lock3 !== 4'h0) begin fails++; $display("FAIL mid_lock got %h/%h want 0", lock1, lock3); end
        vec++; if (err1 !== 1'b0) begin fails++; $display("FAIL mid_err got %h want 0", err1); end
        rreq = 1'b0; reb = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++; if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0) begin
                fails++; $display("FAIL mid_post%0d got %h/%h want 0", i, rvalid1, rvalid3); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_busy_stall();
        test_gaps_lat3();
        test_abort();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
